// File: rtl/busarb_pkg.sv
// Shared types and helpers for the dbus round-robin arbiter.
package busarb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // msize encoding: transfer is (1 << size) bytes
  localparam logic [2:0] MSIZE_B = 3'd0;
  localparam logic [2:0] MSIZE_H = 3'd1;
  localparam logic [2:0] MSIZE_W = 3'd2;
  localparam logic [2:0] MSIZE_D = 3'd3;

  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr, modulo NCH.
module rr_picker #(
  parameter  int NCH = 2,
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic           any,
  output logic [IW-1:0]  idx
);

  logic [2*NCH-1:0] w_dbl;
  logic [NCH-1:0]   w_rot;
  int unsigned      w_off;
  int unsigned      w_sum;

  // Rotating a doubled copy puts channel ptr at bit 0; lowest set bit wins.
  always_comb begin
    w_dbl = {req, req};
    w_rot = NCH'(w_dbl >> ptr);
    w_off = 0;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (w_rot[i-1]) w_off = i - 1;
    end
    w_sum = w_off + 32'(ptr);
    if (w_sum >= NCH) w_sum = w_sum - NCH;
    any = |req;
    idx = IW'(w_sum);
  end

endmodule

// File: rtl/dbus_arbiter.sv
// N-channel round-robin dbus arbiter with a registered, held downstream request.
// Optional perf counters enabled by defining DBUS_ARB_PERF_EN.
module dbus_arbiter
  import busarb_pkg::*;
#(
  parameter  int NCH = 2,
  parameter  int AW  = 64,
  parameter  int DW  = 64,
  parameter  int SZW = 3,
  parameter  int CW  = 32,
  localparam int SW  = DW / 8,
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     up_valid,
  input  logic [NCH*AW-1:0]  up_addr,
  input  logic [NCH*SZW-1:0] up_size,
  input  logic [NCH*DW-1:0]  up_data,
  input  logic [NCH*SW-1:0]  up_strobe,
  output logic [NCH-1:0]     up_data_ok,
  output logic [DW-1:0]      up_rdata,
  output logic               dn_valid,
  output logic [AW-1:0]      dn_addr,
  output logic [SZW-1:0]     dn_size,
  output logic [DW-1:0]      dn_data,
  output logic [SW-1:0]      dn_strobe,
  input  logic               dn_data_ok,
  input  logic [DW-1:0]      dn_rdata,
  output logic [NCH*CW-1:0]  grant_cnt,
  output logic [CW-1:0]      wait_cnt
);

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [SZW-1:0] size;
    logic [DW-1:0]  data;
    logic [SW-1:0]  strobe;
  } dn_req_t;

  arb_state_e    r_state;
  arb_state_e    w_state_nx;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_gnt;
  dn_req_t       r_req;
  dn_req_t       w_ch_req [NCH];
  logic          w_any;
  logic [IW-1:0] w_idx;
  logic          w_latch;
  logic          w_done;
  logic          w_cmpl;

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      w_ch_req[c].addr   = up_addr[c*AW +: AW];
      w_ch_req[c].size   = up_size[c*SZW +: SZW];
      w_ch_req[c].data   = up_data[c*DW +: DW];
      w_ch_req[c].strobe = up_strobe[c*SW +: SW];
    end
  end

  rr_picker #(.NCH(NCH)) u_pick (
    .req (up_valid),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  always_comb begin
    w_state_nx = r_state;
    w_latch    = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nx = BUSY;
          w_latch    = 1'b1;
        end
      end
      BUSY: begin
        if (dn_data_ok) begin
          w_state_nx = IDLE;
          w_done     = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_latch) begin
        r_gnt <= w_idx;
        r_req <= w_ch_req[w_idx];
      end
      if (w_done) r_ptr <= IW'(rr_next(32'(r_gnt), NCH));
    end
  end

  // A completion coinciding with reset is abandoned, so no pulse escapes.
  assign w_cmpl     = w_done & ~reset;
  assign up_data_ok = w_cmpl ? (NCH'(1) << r_gnt) : '0;
  assign up_rdata   = w_cmpl ? dn_rdata : '0;

  assign dn_valid  = (r_state == BUSY);
  assign dn_addr   = r_req.addr;
  assign dn_size   = r_req.size;
  assign dn_data   = r_req.data;
  assign dn_strobe = r_req.strobe;

`ifdef DBUS_ARB_PERF_EN
  logic [CW-1:0]  r_gcnt [NCH];
  logic [CW-1:0]  r_wcnt;
  logic [NCH-1:0] w_own_mask;
  logic           w_wait;

  assign w_own_mask = (r_state == BUSY) ? (NCH'(1) << r_gnt) : '0;
  assign w_wait     = |(up_valid & ~w_own_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt <= '0;
      for (int unsigned c = 0; c < NCH; c++) r_gcnt[c] <= '0;
    end else begin
      if (w_wait && (r_wcnt != '1)) r_wcnt <= r_wcnt + 1'b1;
      if (w_done && (r_gcnt[r_gnt] != '1)) r_gcnt[r_gnt] <= r_gcnt[r_gnt] + 1'b1;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) grant_cnt[c*CW +: CW] = r_gcnt[c];
  end
  assign wait_cnt = r_wcnt;
`else
  assign grant_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized and directed bench for dbus_arbiter (NCH=4, CW=4) against a transaction-level model.
module tb_dbus_arbiter;
  import busarb_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int SZW = 3;
  localparam int SW  = 8;
  localparam int CW  = 4;
  localparam int CMAX = 15;

  logic               clk;
  logic               reset;
  logic [NCH-1:0]     up_valid;
  logic [NCH*AW-1:0]  up_addr;
  logic [NCH*SZW-1:0] up_size;
  logic [NCH*DW-1:0]  up_data;
  logic [NCH*SW-1:0]  up_strobe;
  logic [NCH-1:0]     up_data_ok;
  logic [DW-1:0]      up_rdata;
  logic               dn_valid;
  logic [AW-1:0]      dn_addr;
  logic [SZW-1:0]     dn_size;
  logic [DW-1:0]      dn_data;
  logic [SW-1:0]      dn_strobe;
  logic               dn_data_ok;
  logic [DW-1:0]      dn_rdata;
  logic [NCH*CW-1:0]  grant_cnt;
  logic [CW-1:0]      wait_cnt;

  dbus_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .SZW(SZW), .CW(CW)) u_dut (
    .clk(clk), .reset(reset),
    .up_valid(up_valid), .up_addr(up_addr), .up_size(up_size),
    .up_data(up_data), .up_strobe(up_strobe),
    .up_data_ok(up_data_ok), .up_rdata(up_rdata),
    .dn_valid(dn_valid), .dn_addr(dn_addr), .dn_size(dn_size),
    .dn_data(dn_data), .dn_strobe(dn_strobe),
    .dn_data_ok(dn_data_ok), .dn_rdata(dn_rdata),
    .grant_cnt(grant_cnt), .wait_cnt(wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Requester side
  logic        rq_v [NCH];
  logic [63:0] rq_a [NCH];
  logic [2:0]  rq_s [NCH];
  logic [63:0] rq_d [NCH];
  logic [7:0]  rq_b [NCH];
  bit          auto_re [NCH];
  bit          rnd_mode;
  int          ok_delay;
  bit          fix_rd;
  logic [63:0] fix_rdata;
  logic [2:0]  sz_tab [4];

  // Reference model
  bit          m_busy;
  int          m_own;
  int          m_ptr;
  int          m_bcyc;
  logic [63:0] m_a, m_d;
  logic [2:0]  m_s;
  logic [7:0]  m_b;
  int          m_gcnt [NCH];
  int          m_wcnt;
  logic [NCH-1:0] m_pulse;
  int          q_gnt [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_ptr = 0; m_bcyc = 0;
    m_a = '0; m_d = '0; m_s = '0; m_b = '0;
    for (int c = 0; c < NCH; c++) m_gcnt[c] = 0;
    m_wcnt = 0;
    m_pulse = '0;
  endtask

  task automatic issue(input int c, input logic [63:0] a, input logic [2:0] s,
                       input logic [63:0] d, input logic [7:0] b);
    rq_v[c] = 1'b1; rq_a[c] = a; rq_s[c] = s; rq_d[c] = d; rq_b[c] = b;
  endtask

  task automatic issue_rand(input int c);
    logic [7:0] b;
    b = ($urandom % 2 == 0) ? 8'h00 : 8'($urandom);
    issue(c, {$urandom, $urandom}, sz_tab[$urandom % 4], {$urandom, $urandom}, b);
  endtask

  task automatic step();
    logic [NCH-1:0] drop;
    logic [NCH-1:0] e_ok;
    logic [63:0]    e_rd;
    logic [NCH*CW-1:0] e_gc;
    logic [CW-1:0]  e_wc;
    bit             done, found, nw;
    int             c;
    drop = '0;
    if (rnd_mode && m_busy && ($urandom % 8 == 0)) drop[m_own] = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      up_valid[i]             = rq_v[i] && !drop[i];
      up_addr[i*AW +: AW]     = rq_a[i];
      up_size[i*SZW +: SZW]   = rq_s[i];
      up_data[i*DW +: DW]     = rq_d[i];
      up_strobe[i*SW +: SW]   = rq_b[i];
    end
    if (ok_delay < 0) dn_data_ok = ($urandom % 3 == 0);
    else              dn_data_ok = m_busy && (m_bcyc == ok_delay);
    dn_rdata = fix_rd ? fix_rdata : {$urandom, $urandom};

    @(negedge clk);
    done = m_busy && dn_data_ok && !reset;
    e_ok = done ? (NCH'(1) << m_own) : '0;
    e_rd = done ? dn_rdata : '0;
`ifdef DBUS_ARB_PERF_EN
    for (int i = 0; i < NCH; i++) e_gc[i*CW +: CW] = CW'(m_gcnt[i]);
    e_wc = CW'(m_wcnt);
`else
    e_gc = '0;
    e_wc = '0;
`endif
    chk("dn_valid",   dn_valid,   m_busy);
    chk("dn_addr",    dn_addr,    m_a);
    chk("dn_size",    dn_size,    m_s);
    chk("dn_data",    dn_data,    m_d);
    chk("dn_strobe",  dn_strobe,  m_b);
    chk("up_data_ok", up_data_ok, e_ok);
    chk("up_rdata",   up_rdata,   e_rd);
    chk("grant_cnt",  grant_cnt,  e_gc);
    chk("wait_cnt",   wait_cnt,   e_wc);
    for (int i = 0; i < NCH; i++) if (up_data_ok[i]) q_gnt.push_back(i);
    m_pulse = e_ok;

    if (reset) begin
      model_reset();
    end else begin
      nw = 0;
      for (int i = 0; i < NCH; i++) if (up_valid[i] && !(m_busy && i == m_own)) nw = 1;
      if (nw && m_wcnt < CMAX) m_wcnt++;
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < NCH; k++) begin
          c = (m_ptr + k) % NCH;
          if (!found && up_valid[c]) begin
            found = 1; m_own = c;
            m_a = rq_a[c]; m_s = rq_s[c]; m_d = rq_d[c]; m_b = rq_b[c];
          end
        end
        if (found) begin m_busy = 1; m_bcyc = 0; end
      end else if (dn_data_ok) begin
        m_busy = 0;
        m_ptr  = (m_own + 1) % NCH;
        if (m_gcnt[m_own] < CMAX) m_gcnt[m_own]++;
      end else begin
        m_bcyc++;
      end
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (m_pulse[i]) begin
        rq_v[i] = 1'b0;
        if (auto_re[i]) issue_rand(i);
      end
      if (rnd_mode && !rq_v[i] && ($urandom % 4 == 0)) issue_rand(i);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < NCH; i++) begin rq_v[i] = 1'b0; auto_re[i] = 0; end
    repeat (n) step();
    reset = 1'b0;
    q_gnt.delete();
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (q_gnt.size() < n && cyc < budget) begin
      step();
      cyc++;
    end
    chk(tag, 64'(q_gnt.size()), 64'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    sz_tab[0] = MSIZE_B; sz_tab[1] = MSIZE_H; sz_tab[2] = MSIZE_W; sz_tab[3] = MSIZE_D;
    rnd_mode = 0; ok_delay = 0; fix_rd = 0; fix_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      rq_v[i] = 0; rq_a[i] = '0; rq_s[i] = '0; rq_d[i] = '0; rq_b[i] = '0; auto_re[i] = 0;
    end
    up_valid = '0; up_addr = '0; up_size = '0; up_data = '0; up_strobe = '0;
    dn_data_ok = 0; dn_rdata = '0;
    model_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    do_reset(2);

    // 1: lone ch0 read, completion 3 cycles after dn_valid
    fix_rd = 1; fix_rdata = 64'hDEAD; ok_delay = 3;
    issue(0, 64'h8000_0010, MSIZE_D, 64'h0, 8'h00);
    run_until("t1_done", 1, 50);
    repeat (3) step();
    chk("t1_pulses", 64'(q_gnt.size()), 64'd1);
    if (q_gnt.size() > 0) chk("t1_gnt", 64'(q_gnt[0]), 64'd0);
    fix_rd = 0;

    // 2: ch0 and ch1 held continuously alternate
    do_reset(1);
    ok_delay = 1; auto_re[0] = 1; auto_re[1] = 1;
    issue_rand(0); issue_rand(1);
    run_until("t2_done", 4, 100);
    for (int i = 0; i < 4 && i < q_gnt.size(); i++) chk("t2_order", 64'(q_gnt[i]), 64'(i % 2));

    // 3: rr_ptr=2 with ch1,ch3 pending -> 3 then 1, pointer back at 2
    do_reset(1);
    ok_delay = 2;
    issue_rand(1);
    run_until("t3_prep", 1, 50);
    q_gnt.delete();
    issue_rand(1); issue_rand(3);
    run_until("t3_done", 2, 50);
    if (q_gnt.size() >= 2) begin
      chk("t3_first", 64'(q_gnt[0]), 64'd3);
      chk("t3_second", 64'(q_gnt[1]), 64'd1);
    end
    q_gnt.delete();
    for (int i = 0; i < NCH; i++) issue_rand(i);
    run_until("t3_ptr", 1, 50);
    if (q_gnt.size() >= 1) chk("t3_next", 64'(q_gnt[0]), 64'd2);

    // 4: held write with slow completion
    do_reset(1);
    ok_delay = 5;
    issue(1, 64'h8010_0008, MSIZE_D, 64'h1122_3344_5566_7788, 8'hF0);
    step();
    chk("t4_strobe", 64'(dn_strobe), 64'hF0);
    run_until("t4_done", 1, 50);

    // 5: reset two cycles into BUSY abandons the transaction
    do_reset(1);
    ok_delay = 10;
    issue_rand(0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_dnvalid", 64'(dn_valid), 64'd0);
    chk("t5_nopulse", 64'(q_gnt.size()), 64'd0);
    run_until("t5_done", 1, 50);
    if (q_gnt.size() >= 1) chk("t5_gnt", 64'(q_gnt[0]), 64'd0);

    // 6: 20 ch0 transactions saturate a 4-bit grant counter
    do_reset(1);
    ok_delay = 0; auto_re[0] = 1;
    issue_rand(0); issue_rand(2);
    run_until("t6_done", 21, 300);
    auto_re[0] = 0;
`ifdef DBUS_ARB_PERF_EN
    chk("t6_gcnt0", 64'(grant_cnt[CW-1:0]), 64'd15);
`else
    chk("t6_gcnt0", 64'(grant_cnt[CW-1:0]), 64'd0);
    chk("t6_wcnt", 64'(wait_cnt), 64'd0);
`endif

    // Random traffic, including dn_data_ok in IDLE and owner valid drops
    do_reset(1);
    rnd_mode = 1; ok_delay = -1;
    repeat (3000) step();
    rnd_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
